boot_loader: RTL
================

# boot_loader

Upstream of the core top level. Receives a program image over a UART line, writes it word-by-word into instruction memory, and holds the core in reset (drives the core's `reset_n_out`) until the image has been received and checksum-verified. The core is only released after a good load.

## Interface
- `CLK_HZ`, default 100_000_000: `i_clk` frequency.
- `BAUD`, default 115_200: UART bit rate. Cycles per bit: `CPB = CLK_HZ / BAUD`, integer division; `CPB >= 4` required.
- `ADDR_BASE`, default 32'h0000_0000: byte address of the first word written.
- `MAX_WORDS`, default 1024: largest accepted image, in words.
- `TIMEOUT`, default 2**20: maximum idle cycles between bytes inside a frame.

Ports:
- `i_clk` in 1: single clock, shared with the core.
- `i_reset` in 1: synchronous, active-high reset.
- `i_uart_rx` in 1: asynchronous serial input, 8N1, idles high.
- `o_mem_we` in/out: out 1, one-cycle instruction-memory write strobe.
- `o_mem_addr` out 32: byte address, word-aligned.
- `o_mem_wdata` out 32: write data.
- `o_core_reset_n` out 1: active-low core reset. Connects to the top level's `reset_n_out`.
- `o_busy` out 1: high while a frame is in progress.
- `o_error` out 1: sticky. Set by any frame error; cleared when the next sync byte arrives or by `i_reset`.

## Operation
- **Frame format:**
  - sync byte 0xA5,
  - LEN_LO, LEN_HI: word count N, little-endian,
  - N×4 data bytes, each word little-endian,
  - CHK: XOR of every byte after sync, including the length bytes.
- **UART receiver:**
  - 2-FF synchronizer on `i_uart_rx`.
  - A falling edge starts a byte. The start bit is re-checked at CPB/2 and aborted if high.
  - Data bits are sampled at CPB/2 + k·CPB, LSB first.
  - The stop bit is sampled at mid-bit. A stop bit of 0 is a framing error.
  - One-cycle `rx_valid` pulse with `rx_data[7:0]` at the stop-bit sample.
- **FSM states:** IDLE, LEN0, LEN1, DATA, CHK, DONE.
  - IDLE: `rx_valid` with 0xA5 goes to LEN0 and clears `o_error`. Any other byte is ignored.
  - LEN0 → LEN1 on a byte.
  - LEN1 → DATA if 0 < N ≤ MAX_WORDS; → CHK if N = 0; → IDLE with `o_error` set if N > MAX_WORDS.
  - DATA: bytes are assembled into a 32-bit shift register, byte 0 in bits 7:0. On the 4th byte:
    - pulse `o_mem_we` with `o_mem_addr = ADDR_BASE + 4·word_idx`,
    - increment `word_idx`,
    - after word N-1 → CHK.
  - CHK: byte equal to the running XOR → DONE. Mismatch → IDLE with `o_error` set.
  - DONE: `o_core_reset_n` = 1. A sync byte 0xA5 re-enters LEN0 and drives `o_core_reset_n` low again. All other bytes are ignored.
- **Error conditions:**
  - Framing error in any state other than IDLE/DONE: `o_error` set, → IDLE, core stays in reset.
  - Framing error in IDLE/DONE: byte dropped, no state change.
  - Inter-byte timeout counter runs in LEN0–CHK and resets on each `rx_valid`. Reaching TIMEOUT: `o_error` set, → IDLE.
- `o_core_reset_n` is 1 only in DONE. A failed reload leaves the core in reset.
- Address arithmetic is 32-bit modulo. `word_idx` is $clog2(MAX_WORDS+1) bits wide.

## Timing
- **Reset values** (`i_reset` high at a clock edge, from any state or mid-byte, takes effect next cycle):
  - FSM = IDLE, `o_mem_we` = 0, `o_mem_addr` = ADDR_BASE, `o_mem_wdata` = 0, `o_core_reset_n` = 0, `o_busy` = 0, `o_error` = 0.
  - The UART receiver returns to idle and requires a new falling edge.
- **Latencies:**
  - Line to sync output: 2 cycles.
  - 4th data byte's `rx_valid` to `o_mem_we`: 1 cycle. `o_mem_addr`/`o_mem_wdata` are valid in the same cycle as `o_mem_we` and held until the next write.
  - CHK `rx_valid` to `o_core_reset_n` rising: 1 cycle.
- Minimum spacing between write strobes is 4·10·CPB cycles, so no backpressure input is needed.
- `o_busy` = 1 in LEN0, LEN1, DATA and CHK. It is registered, same timing as the state.

## Structure
- Package `boot_pkg`: state enum `boot_state_t`, constant `SYNC_BYTE = 8'hA5`.
- Sub-module `uart_rx`:
  - params CPB,
  - ports `i_clk`, `i_reset`, `i_rx`, `o_valid`, `o_data[7:0]`, `o_frame_err`.
- Top FSM, assembler, checksum and timeout counter live in `boot_loader`.

## Test plan
Test configuration: CLK_HZ=64, BAUD=4 (CPB=16), MAX_WORDS=4, TIMEOUT=1000.
- **Good frame:** A5 02 00 78 56 34 12 EF BE AD DE CHK=0x02^0x00^...^0xDE
  - writes 0x12345678 @0x0, then 0xDEADBEEF @0x4,
  - `o_core_reset_n` rises 1 cycle after CHK,
  - `o_error` = 0.
- **Bad checksum:** same frame with CHK xor 0x01 → no release, `o_error` = 1, state IDLE. A following good frame releases the core and clears `o_error`.
- **Length limits:**
  - N=5 → `o_error` after LEN1, no writes.
  - N=0 with CHK=0x00 → DONE, no writes.
- **Framing error and glitch:**
  - Stop bit forced 0 on the 3rd data byte → `o_error`, IDLE, 0 further writes.
  - A start-bit glitch shorter than 8 cycles produces no byte.
- **Timeout:** line idle for 1000 cycles after LEN0 → `o_error`, IDLE.
- **Reset and reload:**
  - `i_reset` pulse mid-DATA → all outputs at reset values next cycle.
  - Sync byte while in DONE → `o_core_reset_n` = 0 and a reload proceeds.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader.
package boot_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLen0,
        StLen1,
        StData,
        StChk,
        StDone
    } boot_state_t;

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, one-cycle valid or framing-error pulse.
module uart_rx
    import boot_pkg::*;
#(
    parameter int unsigned CPB = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_frame_err
);

    localparam int unsigned CW = $clog2(CPB);
    localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CPB - 1);

    logic meta_q, sync_q, prev_q;
    rx_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d, data_q, data_d;
    logic valid_q, valid_d, ferr_q, ferr_d;

    // Synchronizer flops reset low so a line held low through reset cannot fake a start edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= i_rx;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            RxIdle: begin
                cnt_d = '0;
                if (prev_q && !sync_q) state_d = RxStart;
            end
            RxStart: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync_q ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RxStop;
                end
            end
            RxStop: begin
                if (cnt_q == FULL_M1) begin
                    state_d = RxIdle;
                    if (sync_q) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = RxIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= RxIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_data      = data_q;
    assign o_frame_err = ferr_q;

endmodule

// File: rtl/boot_loader.sv
// Receives a checksummed program image over UART, writes it to instruction memory,
// and holds the core in reset until a complete, verified image has been loaded.
module boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned BAUD      = 115_200,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024,
    parameter int unsigned TIMEOUT   = 2**20
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_uart_rx,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_core_reset_n,
    output logic        o_busy,
    output logic        o_error
);

    localparam int unsigned CPB = CLK_HZ / BAUD;
    localparam int unsigned IW  = $clog2(MAX_WORDS + 1);
    localparam int unsigned TW  = $clog2(TIMEOUT + 1);

    logic       rx_valid, rx_ferr;
    logic [7:0] rx_data;

    uart_rx #(.CPB(CPB)) u_rx (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_rx       (i_uart_rx),
        .o_valid    (rx_valid),
        .o_data     (rx_data),
        .o_frame_err(rx_ferr)
    );

    boot_state_t state_q, state_d;
    logic [15:0] len_q, len_d, n_word;
    logic [IW-1:0] idx_q, idx_d;
    logic [1:0] bcnt_q, bcnt_d;
    logic [23:0] shift_q, shift_d;
    logic [7:0] chk_q, chk_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic err_q, err_d, we_q, we_d, busy;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;

    assign busy = state_q inside {StLen0, StLen1, StData, StChk};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        chk_d   = chk_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        tmo_d   = busy ? tmo_q + 1'b1 : '0;
        n_word  = {rx_data, len_q[7:0]};
        unique case (state_q)
            StIdle, StDone: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_d = StLen0;
                    err_d   = 1'b0;
                end
            end
            StLen0: begin
                if (rx_valid) begin
                    len_d[7:0] = rx_data;
                    chk_d      = rx_data;
                    state_d    = StLen1;
                end
            end
            StLen1: begin
                if (rx_valid) begin
                    len_d  = n_word;
                    chk_d  = chk_q ^ rx_data;
                    idx_d  = '0;
                    bcnt_d = '0;
                    if (n_word == 16'd0) begin
                        state_d = StChk;
                    end else if (32'(n_word) > MAX_WORDS) begin
                        state_d = StIdle;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (rx_valid) begin
                    chk_d   = chk_q ^ rx_data;
                    shift_d = {rx_data, shift_q[23:8]};
                    bcnt_d  = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = ADDR_BASE + (32'(idx_q) << 2);
                        wdata_d = {rx_data, shift_q};
                        idx_d   = idx_q + 1'b1;
                        if (32'(idx_q) + 32'd1 == 32'(len_q)) state_d = StChk;
                    end
                end
            end
            StChk: begin
                if (rx_valid) begin
                    if (rx_data == chk_q) begin
                        state_d = StDone;
                    end else begin
                        state_d = StIdle;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // In-frame aborts override the per-state decisions above.
        if (busy) begin
            if (rx_valid) begin
                tmo_d = '0;
            end else if (rx_ferr || tmo_q == TW'(TIMEOUT - 1)) begin
                state_d = StIdle;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StIdle;
            len_q   <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
            chk_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= ADDR_BASE;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            chk_q   <= chk_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign o_mem_we       = we_q;
    assign o_mem_addr     = addr_q;
    assign o_mem_wdata    = wdata_q;
    assign o_core_reset_n = (state_q == StDone);
    assign o_busy         = busy;
    assign o_error        = err_q;

endmodule
